prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
Byte-stream program loader that fills the mini CPU instruction memory before execution. It receives a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes the words to consecutive memory addresses starting at 0, verifies an XOR checksum, and holds the CPU halted until the load completes successfully. It drives the write side of the memory whose read side is the CPU fetch stage.

Parameters:
ADDR_W, 10, instruction memory address width
MEM_DEPTH, 1024, maximum loadable word count (must be <= 2**ADDR_W)
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk1  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data holds a byte
in_data  input  8  stream byte
in_ready  output  1  loader accepts a byte this cycle
clear  input  1  return from DONE/ERR to IDLE
mem_we  output  1  instruction memory write strobe
mem_addr  output  ADDR_W  write word address
mem_wdata  output  32  write word
cpu_halt  output  1  holds the CPU (and its pc at 0) while high
load_done  output  1  load succeeded (level)
load_err  output  1  load failed (level)

Behaviour:
- One clock (clk1); reset is asynchronous, active-low (rst_n).
- Reset values: state=IDLE, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_halt=1, load_done=0, load_err=0, counters and checksum=0. Reset mid-load abandons the frame; memory contents already written are left as is.
- A byte is accepted when in_valid && in_ready on a rising edge.
- in_ready=1 in IDLE, LEN_HI, LEN_LO, DATA and CSUM. in_ready=0 in DONE and ERR.
- State IDLE: a non-SYNC_BYTE byte is discarded. SYNC_BYTE moves the FSM to LEN_HI.
- State LEN_HI: the byte is the high byte of the 16-bit word count N. Go to LEN_LO.
- State LEN_LO: the byte is the low byte of N.
  - N==0 or N>MEM_DEPTH: go to ERR on this edge.
  - Otherwise: clear the word index, byte index and checksum, then go to DATA.
- State DATA:
  - Each byte shifts into a 32-bit assembly register MSB first and XORs into the 8-bit checksum.
  - On the 4th byte of a word: next cycle mem_we=1 for exactly one cycle, with mem_addr=word index and mem_wdata=the assembled word. Latency is 1 cycle from the accepting edge.
  - The word index increments after each word. After word N-1 the FSM goes to CSUM.
  - Gaps (in_valid low) are allowed anywhere and do not affect state.
- State CSUM: the byte is compared with the running XOR of all 4N data bytes.
  - Match: go to DONE.
  - Mismatch: go to ERR.
- State DONE: cpu_halt=0, load_done=1. These are registered, valid from the cycle after the checksum byte edge.
- State ERR: cpu_halt=1, load_err=1.
- clear in DONE or ERR returns the FSM to IDLE next edge with cpu_halt=1, load_done=0, load_err=0. clear in any other state is ignored.
- in_valid together with clear in DONE/ERR: the byte is not accepted (in_ready=0) and clear wins.
- The final word's mem_we pulse coincides with the CSUM-state cycle. The memory write completes before cpu_halt deasserts.
- mem_addr holds its last value when mem_we=0. mem_addr never exceeds N-1, so there is no wrap.

Decomposition:
- Shared package mini_cpu_pkg holds:
  - the loader state encoding (IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR);
  - the SYNC_BYTE default;
  - the WORD_W=32 constant, shared with mini_cpu memory width.
- One natural sub-module: prog_word_assembler. It holds the byte shift register, the 2-bit byte index and the word-complete strobe. The FSM, counters and checksum stay in prog_loader.

Test Plan:
- Two-word load: A5 00 02 14 01 00 05 14 02 00 07 01 -> mem_we pulses: addr0=0x14010005, addr1=0x14020007; load_done=1, cpu_halt=0. mini_cpu then gives R1=5, R2=7.
- Bad checksum: same frame with last byte 0x00 -> both writes occur, load_err=1, cpu_halt stays 1. clear -> IDLE, load_err=0.
- Length bounds: A5 00 00 -> ERR. A5 04 01 (N=1025 > 1024) -> ERR with no mem_we. N=1024 with a correct checksum -> last write addr=0x3FF, then DONE.
- Stream gaps and noise: bytes 0x00 0xFF before A5, and in_valid deasserted 3 cycles between every data byte -> the leading noise is discarded and the result is identical to the two-word load.
- Async reset mid-DATA: drop rst_n after 5 data bytes -> all outputs reach reset values immediately with cpu_halt=1. The next full frame loads correctly from addr 0.
- DONE backpressure: in DONE, drive in_valid=1 with A5 -> in_ready=0 and nothing is accepted. Assert clear together with in_valid -> IDLE, and a new frame is accepted.

Source files
------------

// File: rtl/mini_cpu_pkg.sv
// Shared definitions for the mini CPU and its program loader:
// loader state encoding, default frame marker and instruction word width.
package mini_cpu_pkg;

    localparam int         WORD_W        = 32;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } loader_state_t;

endpackage

// File: rtl/prog_word_assembler.sv
// Collects stream bytes MSB first into big-endian instruction words and
// flags the byte that completes each word.
module prog_word_assembler
    import mini_cpu_pkg::*;
(
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              byte_en,
    input  logic [7:0]        byte_data,
    output logic [WORD_W-1:0] word,
    output logic              word_done
);

    // Only the three earlier bytes need storage; the fourth is taken live.
    logic [WORD_W-9:0] shift_reg;
    logic [1:0]        idx_reg;

    assign word      = {shift_reg, byte_data};
    assign word_done = byte_en && (idx_reg == 2'd3);

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            idx_reg   <= '0;
        end else if (clr) begin
            shift_reg <= '0;
            idx_reg   <= '0;
        end else if (byte_en) begin
            shift_reg <= word[WORD_W-9:0];
            idx_reg   <= idx_reg + 2'd1;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader: SYNC, 16-bit word count, 4N data bytes, XOR
// checksum. Writes instruction memory from address 0 and releases the CPU on success.
module prog_loader
    import mini_cpu_pkg::*;
#(
    parameter int         ADDR_W    = 10,
    parameter int         MEM_DEPTH = 1024,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              clear,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_halt,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [15:0] MAX_N = 16'(MEM_DEPTH);

    loader_state_t     state_reg, state_next;
    logic [7:0]        len_hi_reg;
    logic [15:0]       last_idx_reg;
    logic [15:0]       word_idx_reg;
    logic [7:0]        csum_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [WORD_W-1:0] mem_wdata_reg;
    logic              halt_reg, done_reg, err_reg;

    logic              accept;
    logic              data_byte;
    logic              len_lo_byte;
    logic [15:0]       n_value;
    logic [WORD_W-1:0] word;
    logic              word_done;

    assign in_ready    = (state_reg != ST_DONE) && (state_reg != ST_ERR);
    assign accept      = in_valid && in_ready;
    assign data_byte   = accept && (state_reg == ST_DATA);
    assign len_lo_byte = accept && (state_reg == ST_LEN_LO);
    assign n_value     = {len_hi_reg, in_data};

    prog_word_assembler u_asm (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .clr       (len_lo_byte),
        .byte_en   (data_byte),
        .byte_data (in_data),
        .word      (word),
        .word_done (word_done)
    );

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (accept && in_data == SYNC_BYTE) state_next = ST_LEN_HI;
            ST_LEN_HI: if (accept) state_next = ST_LEN_LO;
            ST_LEN_LO: begin
                if (accept) begin
                    if (n_value == 16'd0 || n_value > MAX_N) state_next = ST_ERR;
                    else                                     state_next = ST_DATA;
                end
            end
            ST_DATA:   if (word_done && word_idx_reg == last_idx_reg) state_next = ST_CSUM;
            ST_CSUM: begin
                if (accept) state_next = (in_data == csum_reg) ? ST_DONE : ST_ERR;
            end
            ST_DONE,
            ST_ERR:    if (clear) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Status flags follow the next state so they are valid right after the deciding edge.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            halt_reg <= 1'b1;
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
        end else begin
            halt_reg <= (state_next != ST_DONE);
            done_reg <= (state_next == ST_DONE);
            err_reg  <= (state_next == ST_ERR);
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            len_hi_reg    <= '0;
            last_idx_reg  <= '0;
            word_idx_reg  <= '0;
            csum_reg      <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            mem_we_reg <= word_done;
            if (accept && state_reg == ST_LEN_HI) len_hi_reg <= in_data;
            if (len_lo_byte) begin
                last_idx_reg <= n_value - 16'd1;
                word_idx_reg <= '0;
                csum_reg     <= '0;
            end
            if (data_byte) csum_reg <= csum_reg ^ in_data;
            if (word_done) begin
                mem_addr_reg  <= word_idx_reg[ADDR_W-1:0];
                mem_wdata_reg <= word;
                word_idx_reg  <= word_idx_reg + 16'd1;
            end
        end
    end

    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign cpu_halt  = halt_reg;
    assign load_done = done_reg;
    assign load_err  = err_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table of frames plus hand-written
// sequences; memory writes are checked against a scoreboard queue.
module tb_prog_loader;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        clear;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_halt;
    logic        load_done;
    logic        load_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        string        name;
        logic [127:0] frame;   // byte 0 in the top 8 bits
        int           nbytes;
        int           gap;
        logic         exp_done;
        logic         exp_err;
        int           nwords;
    } vec_t;
    vec_t tbl[5];

    logic [31:0] two_words[2];

    prog_loader dut (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .clear     (clear),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_halt  (cpu_halt),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk1) begin
        if (rst_n === 1'b1 && mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e.addr));
                check("wr_data", mem_wdata, e.data);
                $display("write addr=%h data=%h", mem_addr, mem_wdata);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk1);
        #1;
        in_valid = 1'b0;
        for (int k = 0; k < gap; k++) begin
            @(posedge clk1);
            #1;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_done"},  32'(load_done), 32'd0);
        check({tag, "_err"},   32'(load_err),  32'd0);
        check({tag, "_halt"},  32'(cpu_halt),  32'd1);
        check({tag, "_ready"}, 32'(in_ready),  32'd1);
    endtask

    task automatic end_frame(input string tag, input logic done, input logic err);
        @(negedge clk1);
        check({tag, "_done"},  32'(load_done), 32'(done));
        check({tag, "_err"},   32'(load_err),  32'(err));
        check({tag, "_halt"},  32'(cpu_halt),  32'(!done));
        check({tag, "_ready"}, 32'(in_ready),  32'(!(done || err)));
        check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
        $display("frame %s: done=%0b err=%0b halt=%0b", tag, load_done, load_err, cpu_halt);
    endtask

    task automatic do_clear(input string tag);
        @(negedge clk1);
        clear = 1'b1;
        @(posedge clk1);
        #1;
        clear = 1'b0;
        @(negedge clk1);
        check_idle({tag, "_clr"});
    endtask

    task automatic push_two_words();
        for (int i = 0; i < 2; i++) exp_q.push_back('{addr: 10'(i), data: two_words[i]});
    endtask

    task automatic send_good_frame();
        logic [95:0] f;
        f = 96'hA50002140100051402000701;
        push_two_words();
        for (int i = 0; i < 12; i++) send_byte(f[95-8*i -: 8], 0);
    endtask

    initial begin
        logic [31:0] w;
        logic [7:0]  csum;
        logic [95:0] f;

        two_words[0] = 32'h14010005;
        two_words[1] = 32'h14020007;
        tbl[0] = '{"two_word",  {96'hA50002140100051402000701, 32'h0},       12, 0, 1'b1, 1'b0, 2};
        tbl[1] = '{"bad_csum",  {96'hA50002140100051402000700, 32'h0},       12, 0, 1'b0, 1'b1, 2};
        tbl[2] = '{"len_zero",  {24'hA50000, 104'h0},                         3, 0, 1'b0, 1'b1, 0};
        tbl[3] = '{"len_1025",  {24'hA50401, 104'h0},                         3, 0, 1'b0, 1'b1, 0};
        tbl[4] = '{"noise_gap", {112'h00FFA50002140100051402000701, 16'h0},  14, 3, 1'b1, 1'b0, 2};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        clear    = 1'b0;
        repeat (2) @(negedge clk1);
        check("rst_ready", 32'(in_ready),  32'd1);
        check("rst_we",    32'(mem_we),    32'd0);
        check("rst_addr",  32'(mem_addr),  32'd0);
        check("rst_wdata", mem_wdata,      32'd0);
        check("rst_halt",  32'(cpu_halt),  32'd1);
        check("rst_done",  32'(load_done), 32'd0);
        check("rst_err",   32'(load_err),  32'd0);
        rst_n = 1'b1;
        @(negedge clk1);

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < tbl[v].nwords; i++)
                exp_q.push_back('{addr: 10'(i), data: two_words[i]});
            for (int i = 0; i < tbl[v].nbytes; i++)
                send_byte(tbl[v].frame[127-8*i -: 8], tbl[v].gap);
            end_frame(tbl[v].name, tbl[v].exp_done, tbl[v].exp_err);
            do_clear(tbl[v].name);
        end

        // Maximum-length frame: 1024 words, last write at 0x3FF.
        send_byte(8'hA5, 0);
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        csum = 8'h00;
        for (int i = 0; i < 1024; i++) begin
            w = 32'hC0DE0000 | 32'(i * 7);
            exp_q.push_back('{addr: 10'(i), data: w});
            for (int b = 0; b < 4; b++) begin
                csum = csum ^ w[31-8*b -: 8];
                send_byte(w[31-8*b -: 8], 0);
            end
        end
        send_byte(csum, 0);
        end_frame("len_1024", 1'b1, 1'b0);
        check("len_1024_last_addr", 32'(mem_addr), 32'h3FF);
        do_clear("len_1024");

        // Asynchronous reset after 5 data bytes; only word 0 is written.
        f = 96'hA50002140100051402000701;
        exp_q.push_back('{addr: 10'd0, data: two_words[0]});
        for (int i = 0; i < 8; i++) send_byte(f[95-8*i -: 8], 0);
        rst_n = 1'b0;
        #1;
        check("arst_ready", 32'(in_ready),  32'd1);
        check("arst_we",    32'(mem_we),    32'd0);
        check("arst_addr",  32'(mem_addr),  32'd0);
        check("arst_wdata", mem_wdata,      32'd0);
        check("arst_halt",  32'(cpu_halt),  32'd1);
        check("arst_done",  32'(load_done), 32'd0);
        check("arst_err",   32'(load_err),  32'd0);
        #2;
        rst_n = 1'b1;
        @(negedge clk1);
        send_good_frame();
        end_frame("after_reset", 1'b1, 1'b0);

        // Backpressure in DONE, then clear together with a valid byte.
        @(negedge clk1);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk1);
            check("bp_ready", 32'(in_ready),  32'd0);
            check("bp_done",  32'(load_done), 32'd1);
        end
        clear = 1'b1;
        @(posedge clk1);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk1);
        check_idle("bp_clr");
        send_good_frame();
        end_frame("after_bp", 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
